// File: rtl/s_init_pkg.sv
// Shared types and mode encodings for the S-array init engine.
package s_init_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FILL     = 3'd1,
      CHK_RD   = 3'd2,
      CHK_LAST = 3'd3,
      FINISH   = 3'd4
   } state_t;

   localparam logic [1:0] MODE_RAMP  = 2'd0;
   localparam logic [1:0] MODE_CONST = 2'd1;
   localparam logic [1:0] MODE_CHECK = 2'd2;
   localparam logic [1:0] MODE_RSVD  = 2'd3;

endpackage

// File: rtl/s_init_if.sv
// Request/response and S-memory port bundle between controller, engine and RAM.
interface s_init_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              en;
   logic              rdy;
   logic [1:0]        mode;
   logic [DATA_W-1:0] fill_val;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wrdata;
   logic              wren;
   logic [DATA_W-1:0] rddata;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   err_count;

   // controller + memory side
   modport master (
      output en, mode, fill_val, rddata,
      input  rdy, addr, wrdata, wren, done, err, err_count
   );

   // engine side
   modport slave (
      input  en, mode, fill_val, rddata,
      output rdy, addr, wrdata, wren, done, err, err_count
   );
endinterface

// File: rtl/s_init_cmp.sv
// Read-back compare stage: holds the expected word for one cycle so it lines up
// with the RAM's 1-cycle read latency, and counts mismatches (saturating).
module s_init_cmp #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              chk_en,
   input  logic [DATA_W-1:0] exp_val,
   input  logic [DATA_W-1:0] rddata,
   output logic              mismatch,
   output logic [ADDR_W:0]   err_count
);

   localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   logic [DATA_W-1:0] exp_q, exp_d;
   logic              vld_q, vld_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;

   // next values for the delayed expected word and the mismatch counter
   always_comb begin
      exp_d    = exp_val;
      vld_d    = chk_en;
      mismatch = vld_q && (rddata != exp_q);
      cnt_d    = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (mismatch && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + (ADDR_W+1)'(1);
      end
   end

   // compare-stage registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q <= '0;
         vld_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         exp_q <= exp_d;
         vld_q <= vld_d;
         cnt_q <= cnt_d;
      end
   end

   assign err_count = cnt_q;

endmodule

// File: rtl/s_init_engine.sv
// S-array initialiser: ramp/constant fill of the S RAM and ramp read-back check.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | rdy=1, waiting for en
// FILL     | one write per cycle, addr 0..DEPTH-1
// CHK_RD   | one read per cycle, addr 0..DEPTH-1, compares trail by one
// CHK_LAST | last read data arriving, final compare
// FINISH   | done pulse, back to IDLE
module s_init_engine
   import s_init_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input logic   clk,
   input logic   rst_n,
   s_init_if.slave bus
);

   state_t            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [DATA_W-1:0] fill_q, fill_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wrdata_q, wrdata_d;
   logic              wren_q, wren_d;
   logic              rdy_q, rdy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              accept;
   logic              last_addr;
   logic [ADDR_W-1:0] addr_inc;
   logic              chk_en;
   logic [DATA_W-1:0] exp_now;
   logic              mismatch;
   logic [ADDR_W:0]   err_count;

   assign accept    = bus.en && rdy_q;
   assign last_addr = &addr_q;
   assign addr_inc  = addr_q + ADDR_W'(1);
   assign chk_en    = (state_q == CHK_RD);
   assign exp_now   = DATA_W'(addr_q) + fill_q;

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mode_q   <= MODE_RAMP;
         fill_q   <= '0;
         addr_q   <= '0;
         wrdata_q <= '0;
         wren_q   <= 1'b0;
         rdy_q    <= 1'b1;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         fill_q   <= fill_d;
         addr_q   <= addr_d;
         wrdata_q <= wrdata_d;
         wren_q   <= wren_d;
         rdy_q    <= rdy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (bus.mode)
                  MODE_RAMP, MODE_CONST: state_d = FILL;
                  MODE_CHECK:            state_d = CHK_RD;
                  default:               state_d = FINISH;
               endcase
            end
         end
         FILL:     if (last_addr) state_d = FINISH;
         CHK_RD:   if (last_addr) state_d = CHK_LAST;
         CHK_LAST: state_d = FINISH;
         FINISH:   state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // next values of the registered outputs; every output is a flop so en never
   // reaches a port combinationally
   always_comb begin
      mode_d   = mode_q;
      fill_d   = fill_q;
      addr_d   = addr_q;
      wrdata_d = wrdata_q;
      wren_d   = 1'b0;
      rdy_d    = rdy_q;
      done_d   = 1'b0;
      err_d    = err_q | mismatch;
      case (state_q)
         IDLE: begin
            if (accept) begin
               mode_d   = bus.mode;
               fill_d   = bus.fill_val;
               addr_d   = '0;
               rdy_d    = 1'b0;
               // word 0 is fill_val for both ramp and constant fill
               wrdata_d = bus.fill_val;
               wren_d   = (bus.mode == MODE_RAMP) || (bus.mode == MODE_CONST);
               err_d    = (bus.mode == MODE_RSVD);
               done_d   = (bus.mode == MODE_RSVD);
            end
         end
         FILL: begin
            if (last_addr) begin
               addr_d = '0;
               done_d = 1'b1;
            end else begin
               addr_d   = addr_inc;
               wren_d   = 1'b1;
               wrdata_d = (mode_q == MODE_CONST) ? fill_q : DATA_W'(addr_inc) + fill_q;
            end
         end
         CHK_RD:   addr_d = last_addr ? '0 : addr_inc;
         CHK_LAST: done_d = 1'b1;
         FINISH:   rdy_d  = 1'b1;
         default: ;
      endcase
   end

   s_init_cmp #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_cmp (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (accept),
      .chk_en    (chk_en),
      .exp_val   (exp_now),
      .rddata    (bus.rddata),
      .mismatch  (mismatch),
      .err_count (err_count)
   );

   assign bus.rdy       = rdy_q;
   assign bus.addr      = addr_q;
   assign bus.wrdata    = wrdata_q;
   assign bus.wren      = wren_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.err_count = err_count;

endmodule

// File: tb/tb_s_init_engine.sv
// Bench for s_init_engine: behavioural RAM, array-level reference model,
// directed scenarios followed by randomized fill/check sequences.
module tb_s_init_engine;
   import s_init_pkg::*;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   s_init_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   s_init_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // behavioural single-port RAM, 1-cycle read latency, with bench back-door ports
   logic [DATA_W-1:0] mem     [DEPTH];
   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic [DATA_W-1:0] rd_q = '0;
   logic              init_req  = 1'b0;
   logic [DATA_W-1:0] init_val  = '0;
   logic              poke_req  = 1'b0;
   logic [ADDR_W-1:0] poke_addr = '0;
   logic [DATA_W-1:0] poke_data = '0;

   always @(posedge clk) begin
      if (init_req) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= init_val;
      end else if (poke_req) begin
         mem[poke_addr] <= poke_data;
      end else if (bus.wren) begin
         mem[bus.addr] <= bus.wrdata;
      end
      rd_q <= mem[bus.addr];
   end

   assign bus.rddata = rd_q;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_init(input logic [DATA_W-1:0] v);
      @(negedge clk);
      init_req = 1'b1;
      init_val = v;
      @(negedge clk);
      init_req = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = v;
   endtask

   task automatic do_poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      @(negedge clk);
      poke_req  = 1'b1;
      poke_addr = a;
      poke_data = d;
      @(negedge clk);
      poke_req = 1'b0;
      ref_mem[a] = d;
   endtask

   function automatic logic [DATA_W-1:0] ramp(input int i, input logic [DATA_W-1:0] fv);
      logic [DATA_W-1:0] iv;
      iv = DATA_W'(i);
      return iv + fv;
   endfunction

   function automatic int model_mismatches(input logic [DATA_W-1:0] fv);
      int n = 0;
      for (int i = 0; i < DEPTH; i++) if (ref_mem[i] !== ramp(i, fv)) n++;
      return (n > DEPTH) ? DEPTH : n;
   endfunction

   task automatic check_mem(input string tag);
      int n = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) n++;
      chk(tag, n, 0);
   endtask

   // one full operation: handshake, latency, wren count, err flags, memory image
   task automatic run_op(input logic [1:0] m, input logic [DATA_W-1:0] fv, input bit en_mid);
      int exp_done, exp_w, exp_cnt, done_c, wcnt;
      logic exp_err, got_err;
      logic [ADDR_W:0] got_cnt;
      case (m)
         MODE_RAMP: begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = ramp(i, fv);
            exp_done = DEPTH + 1; exp_w = DEPTH; exp_err = 1'b0; exp_cnt = 0;
         end
         MODE_CONST: begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = fv;
            exp_done = DEPTH + 1; exp_w = DEPTH; exp_err = 1'b0; exp_cnt = 0;
         end
         MODE_CHECK: begin
            exp_cnt  = model_mismatches(fv);
            exp_err  = (exp_cnt != 0);
            exp_done = DEPTH + 2; exp_w = 0;
         end
         default: begin
            exp_done = 1; exp_w = 0; exp_err = 1'b1; exp_cnt = 0;
         end
      endcase
      @(negedge clk);
      chk("rdy_before", bus.rdy, 1);
      bus.en       = 1'b1;
      bus.mode     = m;
      bus.fill_val = fv;
      @(posedge clk);
      #1;
      bus.en       = 1'b0;
      bus.mode     = 2'($urandom);
      bus.fill_val = DATA_W'($urandom);
      chk("rdy_drop", bus.rdy, 0);
      done_c  = 0;
      wcnt    = 0;
      got_err = 1'b0;
      got_cnt = '0;
      for (int c = 1; c <= DEPTH + 10; c++) begin
         @(negedge clk);
         if (bus.wren) wcnt++;
         if (en_mid && c == 51) bus.en = 1'b0;
         if (bus.done) begin
            done_c  = c;
            got_err = bus.err;
            got_cnt = bus.err_count;
            break;
         end
         if (en_mid && c == 50) begin
            bus.en       = 1'b1;
            bus.mode     = MODE_CHECK;
            bus.fill_val = 8'hEE;
         end
      end
      bus.en = 1'b0;
      chk("done_cycle", done_c, exp_done);
      chk("wren_cycles", wcnt, exp_w);
      chk("err", got_err, exp_err);
      chk("err_count", got_cnt, exp_cnt);
      @(negedge clk);
      chk("done_pulse", bus.done, 0);
      chk("rdy_after", bus.rdy, 1);
      chk("wren_idle", bus.wren, 0);
      if (m == MODE_RAMP || m == MODE_CONST) check_mem("mem_image");
   endtask

   int first_done, second_done;
   logic [DATA_W-1:0] last_ramp_fv;

   initial begin
      bus.en       = 1'b0;
      bus.mode     = MODE_RAMP;
      bus.fill_val = '0;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rdy", bus.rdy, 1);
      chk("rst_wren", bus.wren, 0);
      chk("rst_addr", bus.addr, 0);
      chk("rst_wrdata", bus.wrdata, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_err_count", bus.err_count, 0);
      do_init(8'h00);
      rst_n = 1'b1;

      // plain ramp and wrapped-offset ramp
      run_op(MODE_RAMP, 8'h00, 1'b0);
      run_op(MODE_RAMP, 8'hF0, 1'b0);
      chk("wrap_m0", mem[0], 8'hF0);
      chk("wrap_m15", mem[15], 8'hFF);
      chk("wrap_m16", mem[16], 8'h00);
      chk("wrap_m255", mem[255], 8'hEF);

      // constant fill then check: only word 0x5A matches
      run_op(MODE_CONST, 8'h5A, 1'b0);
      run_op(MODE_CHECK, 8'h00, 1'b0);
      chk("const_chk_cnt", bus.err_count, 255);

      // clean ramp then check: clears the previous error
      run_op(MODE_RAMP, 8'h00, 1'b0);
      run_op(MODE_CHECK, 8'h00, 1'b0);
      chk("clean_err", bus.err, 0);

      // single corruption
      run_op(MODE_RAMP, 8'h00, 1'b0);
      do_poke(8'd37, 8'h00);
      run_op(MODE_CHECK, 8'h00, 1'b0);
      chk("corrupt_cnt", bus.err_count, 1);

      // en pulsed mid-fill is ignored
      run_op(MODE_RAMP, 8'h11, 1'b1);

      // reserved mode
      run_op(MODE_RSVD, 8'h77, 1'b0);
      chk("rsvd_err_sticky", bus.err, 1);

      // en held high: back-to-back restart
      @(negedge clk);
      bus.en       = 1'b1;
      bus.mode     = MODE_CONST;
      bus.fill_val = 8'h33;
      @(posedge clk);
      first_done  = 0;
      second_done = 0;
      for (int c = 1; c <= 3 * DEPTH; c++) begin
         @(negedge clk);
         if (bus.done) begin
            if (first_done == 0) first_done = c;
            else begin
               second_done = c;
               break;
            end
         end else if (first_done != 0 && c == first_done + 1) begin
            chk("b2b_rdy", bus.rdy, 1);
            @(posedge clk);
            #1;
            bus.en = 1'b0;
            chk("b2b_restart", bus.rdy, 0);
         end
      end
      bus.en = 1'b0;
      chk("b2b_first", first_done, DEPTH + 1);
      chk("b2b_second", second_done, 2 * DEPTH + 3);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h33;
      @(negedge clk);
      chk("b2b_rdy_end", bus.rdy, 1);
      check_mem("b2b_mem");

      // reset in the middle of a fill
      run_op(MODE_RSVD, 8'h00, 1'b0);
      do_init(8'hC3);
      @(negedge clk);
      bus.en       = 1'b1;
      bus.mode     = MODE_RAMP;
      bus.fill_val = 8'h20;
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      for (int c = 1; c <= 100; c++) @(negedge clk);
      chk("mid_addr", bus.addr, 99);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rdy", bus.rdy, 1);
      chk("mid_rst_wren", bus.wren, 0);
      chk("mid_rst_addr", bus.addr, 0);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_err", bus.err, 0);
      chk("mid_rst_cnt", bus.err_count, 0);
      for (int i = 0; i < 99; i++) ref_mem[i] = ramp(i, 8'h20);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_mem("mid_rst_mem");
      run_op(MODE_RAMP, 8'h20, 1'b0);
      last_ramp_fv = 8'h20;

      // randomized sequences
      for (int k = 0; k < 10; k++) begin
         logic [1:0] m;
         logic [DATA_W-1:0] fv;
         m  = 2'($urandom_range(0, 3));
         fv = DATA_W'($urandom);
         if (m == MODE_CHECK) begin
            if ($urandom_range(0, 2) != 0) fv = last_ramp_fv;
            if ($urandom_range(0, 1) != 0)
               do_poke(ADDR_W'($urandom), DATA_W'($urandom));
         end
         if (m == MODE_RAMP) last_ramp_fv = fv;
         run_op(m, fv, ($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
